layouta_stream_feeder: RTL
==========================

Name: layouta_stream_feeder

Overview:
- Sits directly downstream of the skew-layout stage (layoutA).
- Captures one skewed feature map (DIM rows x 2*DIM-1 columns of BITS-bit pixels) and the active dims m, n.
- Streams the map one skewed column per beat into the systolic array's row inputs.
- Uses a valid/ready handshake with stall support, zero-masks inactive rows, and flags the last beat plus completion.

Parameters:
- BITS, 8, bit width of each pixel.
- DIM, 32, maximum feature-map dimension and number of output lanes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request to capture a new map; accepted only when in_ready=1.
- in_ready  out  1  high in IDLE; block can accept start.
- m  in  $clog2(DIM)+1  active row count of the map, sampled on accepted start.
- n  in  $clog2(DIM)+1  active column count of the map, sampled on accepted start.
- OUTA  in  [DIM-1:0][DIM*2-2:0] x BITS  skewed map from layoutA, sampled on accepted start.
- out_data  out  [DIM-1:0] x BITS  lane i = pixel of row i in the current skewed column.
- out_valid  out  1  out_data/out_col/out_last valid.
- out_ready  in  1  consumer accepts the beat.
- out_col  out  $clog2(2*DIM-1)  index of the current skewed column.
- out_last  out  1  current beat is column m+n-2.
- busy  out  1  high in STREAM or DONE.
- done  out  1  one-cycle pulse after the last beat transfers.
- err  out  1  one-cycle pulse on an accepted start with illegal dims.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; col counter cleared to 0.
  - Outputs: in_ready=1 (from the next cycle), out_valid=0, out_last=0, busy=0, done=0, err=0, out_col=0, out_data all zero.
  - Buffer contents are don't-care.
  - rst has priority over every other input, including mid-stream.
- States: IDLE, STREAM, DONE, ERR.
- IDLE:
  - in_ready=1.
  - On start=1: latch OUTA into the internal buffer and m, n into registers, and clear col to 0.
  - If 1<=m<=DIM and 1<=n<=DIM, go to STREAM; otherwise go to ERR.
  - Sampled inputs are held; later changes to OUTA, m or n have no effect until the next accepted start.
- STREAM:
  - out_valid=1, in_ready=0, busy=1.
  - out_data[i] = buf[i][col] for i<m_r; out_data[i] = 0 for i>=m_r.
  - out_col=col; out_last=(col==m_r+n_r-2); beat count = m_r+n_r-1.
  - A transfer occurs when out_valid & out_ready.
  - On a non-last transfer, col increments by 1.
  - On the last transfer, go to DONE.
  - With out_ready=0, all outputs hold stable (no change of data/col while valid and not accepted).
  - out_data is driven combinationally from the buffer and registered col; no extra pipeline.
- DONE:
  - One cycle: done=1, busy=1, out_valid=0.
  - Then return to IDLE.
- ERR:
  - One cycle: err=1, busy=0, out_valid=0, no beats issued.
  - Then return to IDLE.
- Latency:
  - Start accepted at edge k: first out_valid is visible in the cycle after edge k.
  - With out_ready held high, beats appear on m+n-1 consecutive cycles, then done is asserted for 1 cycle, then in_ready is high again.
- start while not in IDLE is ignored and has no effect on the current stream.
- out_data is all zero whenever out_valid=0.
- Width rule: m_r+n_r-2 is computed at $clog2(2*DIM-1)+1 bits to avoid overflow at m=n=DIM (max col = 62 for DIM=32).
- Boundary m=n=1: exactly one beat with out_col=0 and out_last=1 on that beat.

Test Plan:
- Reset, then start with m=n=32 and random OUTA, out_ready=1:
  - 63 consecutive beats, out_col 0..62, each lane i equal to OUTA[i][col].
  - out_last only at col 62.
  - done pulses the cycle after; in_ready=1 on the following cycle.
- m=14, n=14, out_ready=1:
  - 27 beats, out_col 0..26.
  - Lanes 14..31 read 0 on every beat even when the same lanes in OUTA are nonzero.
- m=5, n=5, out_ready toggles 1,0,0,1,...:
  - out_data/out_col are stable during stalls; exactly 9 transfers, in order.
  - done follows the 9th transfer.
- m=0, n=5, and separately m=33, n=4:
  - err pulses 1 cycle, out_valid never asserts, block returns to IDLE.
- Mid-stream (col=3, m=n=8): start=1 with new OUTA is ignored.
  - Stream completes with the original data.
  - Then assert rst at col=2 of a new stream: next cycle out_valid=0, busy=0, in_ready=1, out_col=0.
- m=n=1:
  - Single beat, out_col=0, out_last=1, out_data[0]=OUTA[0][0], other lanes 0, then done.

Source files
------------

// File: rtl/layouta_stream_feeder.sv
// layouta_stream_feeder
//   Captures one skewed feature map from the layoutA stage together with its
//   active dims (m, n) and streams it to the systolic array one skewed column
//   per beat over a valid/ready handshake.
//
// Ports
//   clk, rst       : clock (rising edge), synchronous active-high reset
//   start/in_ready : capture request; accepted only while in_ready (IDLE)
//   m, n           : active rows / columns, sampled on accepted start
//   OUTA           : skewed map [row][skewed col][pixel], sampled on start
//   out_data       : lane i = pixel of row i in the current column (0 if i>=m)
//   out_valid/out_ready : beat handshake; outputs hold while stalled
//   out_col        : current skewed column index
//   out_last       : beat is column m+n-2
//   busy           : streaming or finishing
//   done           : one-cycle pulse after the last beat transfers
//   err            : one-cycle pulse on an accepted start with illegal dims

// Per-lane column select with row masking.
module layouta_lane #(
  parameter int BITS = 8,
  parameter int DIM  = 32,
  parameter int CW   = $clog2(2*DIM-1)
) (
  input  logic [2*DIM-2:0][BITS-1:0] row_i,
  input  logic [CW-1:0]              col_i,
  input  logic                       en_i,
  output logic [BITS-1:0]            pix_o
);
  assign pix_o = en_i ? row_i[col_i] : '0;
endmodule

module layouta_stream_feeder #(
  parameter int BITS = 8,
  parameter int DIM  = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   in_ready,
  input  logic [$clog2(DIM):0]                   m,
  input  logic [$clog2(DIM):0]                   n,
  input  logic [DIM-1:0][DIM*2-2:0][BITS-1:0]    OUTA,
  output logic [DIM-1:0][BITS-1:0]               out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(2*DIM-1)-1:0]             out_col,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);
  localparam int MW = $clog2(DIM) + 1;
  localparam int CW = $clog2(2*DIM-1);
  localparam int LW = CW + 1;  // m+n-2 reaches 2*DIM-2; one extra bit for the sum

  typedef enum logic [1:0] {IDLE, STREAM, DONE, ERR} state_e;

  state_e                              state_q;
  logic [CW-1:0]                       col_q;
  logic [MW-1:0]                       m_q, n_q;
  logic [DIM-1:0][2*DIM-2:0][BITS-1:0] buf_q;

  logic [LW-1:0] last_col;
  logic          is_last;
  logic          dims_ok;

  assign last_col = LW'(m_q) + LW'(n_q) - LW'(2);
  assign is_last  = ({1'b0, col_q} == last_col);
  assign dims_ok  = (m >= MW'(1)) && (m <= MW'(DIM)) &&
                    (n >= MW'(1)) && (n <= MW'(DIM));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          buf_q   <= OUTA;
          m_q     <= m;
          n_q     <= n;
          col_q   <= '0;
          state_q <= dims_ok ? STREAM : ERR;
        end
        STREAM: if (out_ready) begin
          if (is_last) begin
            // park col at 0 so out_col reads 0 whenever idle
            col_q   <= '0;
            state_q <= DONE;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign out_last  = out_valid && is_last;
  assign out_col   = col_q;

  // Lane enable folds in out_valid so out_data is zero outside STREAM.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    layouta_lane #(.BITS(BITS), .DIM(DIM), .CW(CW)) u_lane (
      .row_i (buf_q[i]),
      .col_i (col_q),
      .en_i  (out_valid && (MW'(i) < m_q)),
      .pix_o (out_data[i])
    );
  end

endmodule
